// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - program sequencer that drives an 8-bit registered ALU
//
// Fetches 13-bit instructions from a small program memory, drives the ALU
// accum/data/opcode inputs and writes the ALU result back into the accumulator.
// Optional feature macro: INSTR_COUNT_EN (adds the retired output).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   prog_we/addr/data       program write port, honoured only while idle
//   start, acc_init         start pulse and initial accumulator value
//   busy, done, error       run status (busy level, done pulse, step-limit abort)
//   accum, data, opcode     ALU operand/opcode drive
//   alu_out, zero           registered ALU result and accumulator zero flag
//   retired                 instructions retired in the last/current run (INSTR_COUNT_EN)

module alu_sequencer #(
  parameter int AW        = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [12:0]   prog_data,
  input  logic          start,
  input  logic [7:0]    acc_init,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    accum,
  output logic [7:0]    data,
  output logic [2:0]    opcode,
  input  logic [7:0]    alu_out,
  input  logic          zero
`ifdef INSTR_COUNT_EN
  ,
  output logic [7:0]    retired
`endif
);

  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [7:0]  MAX_STEP8 = 8'(MAX_STEPS);

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_BZ   = 2'b01;
  localparam logic [1:0] KIND_HALT = 2'b10;
  localparam logic [1:0] KIND_NOP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_FIN
  } state_t;

  state_t          state_q;
  logic [12:0]     mem_q [DEPTH];
  logic [AW-1:0]   pc_q;
  logic [7:0]      steps_q;
  logic [1:0]      kind_q;
  logic [AW-1:0]   target_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic [7:0]      accum_q;
  logic [7:0]      data_q;
  logic [2:0]      opcode_q;

  logic [12:0]     fetch_word;
  logic [AW-1:0]   pc_d;
  logic [7:0]      steps_d;
  logic            limit_hit;

  assign fetch_word = mem_q[pc_q];
  assign pc_d       = pc_q + 1'b1;
  assign steps_d    = steps_q + 8'd1;
  assign limit_hit  = (steps_d == MAX_STEP8);

  // Program memory is never cleared by reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_IDLE && prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      steps_q  <= '0;
      kind_q   <= KIND_ALU;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      accum_q  <= '0;
      data_q   <= '0;
      opcode_q <= 3'b000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            accum_q <= acc_init;
            pc_q    <= '0;
            steps_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          kind_q   <= fetch_word[12:11];
          target_q <= fetch_word[AW-1:0];
          // Opcode/data are registered here so they are already stable at the
          // ALU inputs for the whole EXEC cycle; other kinds leave them alone
          // so alu_out does not move underneath a pending writeback.
          if (fetch_word[12:11] == KIND_ALU) begin
            opcode_q <= fetch_word[10:8];
            data_q   <= fetch_word[7:0];
          end
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (kind_q)
            KIND_ALU: state_q <= S_WB;
            KIND_BZ, KIND_NOP: begin
              pc_q    <= (kind_q == KIND_BZ && zero) ? target_q : pc_d;
              steps_q <= steps_d;
              if (limit_hit) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                state_q <= S_FETCH;
              end
            end
            default: begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          endcase
        end
        S_WB: begin
          accum_q <= alu_out;
          pc_q    <= pc_d;
          steps_q <= steps_d;
          if (limit_hit) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign accum  = accum_q;
  assign data   = data_q;
  assign opcode = opcode_q;

`ifdef INSTR_COUNT_EN
  // Every retired instruction also advances the step counter, so it doubles
  // as the retired count.
  assign retired = steps_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a registered ALU model

module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [12:0] prog_data;
  logic        start;
  logic [7:0]  acc_init;
  logic        busy, done, error;
  logic [7:0]  accum, data;
  logic [2:0]  opcode;
  logic [7:0]  alu_out;
  logic        zero;
`ifdef INSTR_COUNT_EN
  logic [7:0]  retired;
`endif

  int checks = 0;
  int errors = 0;

  logic [12:0] prog [16];

  alu_sequencer #(.AW(4), .MAX_STEPS(255)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .acc_init(acc_init),
    .busy(busy), .done(done), .error(error), .accum(accum), .data(data),
    .opcode(opcode), .alu_out(alu_out), .zero(zero)
`ifdef INSTR_COUNT_EN
    , .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU opcodes: 0 PASSA, 1 ADD, 2 SUB, 3 AND, 4 XOR, 5 ABS, 6 MUL (signed nibbles), 7 PASSD
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] d, input logic [2:0] op);
    int x, y;
    x = $signed(a[3:0]);
    y = $signed(d[3:0]);
    case (op)
      3'd0: return a;
      3'd1: return a + d;
      3'd2: return a - d;
      3'd3: return a & d;
      3'd4: return a ^ d;
      3'd5: return a[7] ? 8'(-a) : a;
      3'd6: return 8'(x * y);
      default: return d;
    endcase
  endfunction

  initial alu_out = 8'h00;
  always @(posedge clk) alu_out <= alu_fn(accum, data, opcode);
  assign zero = (accum == 8'h00);

  function automatic logic [12:0] enc(input int kind, input int op, input int operand);
    return {2'(kind), 3'(op), 8'(operand)};
  endfunction

  // Program interpreter: ALU 3 cycles, BZ/NOP 2 cycles, HALT 2 cycles to done.
  task automatic model_run(input logic [7:0] a0, output logic [7:0] acc, output logic err,
                           output int steps, output int cyc);
    int pc;
    logic [12:0] w;
    acc = a0; err = 1'b0; steps = 0; cyc = 0; pc = 0;
    while (1) begin
      w = prog[pc];
      if (w[12:11] == 2'b10) begin
        cyc += 2;
        break;
      end else if (w[12:11] == 2'b00) begin
        acc = alu_fn(acc, w[7:0], w[10:8]);
        cyc += 3;
        pc = (pc + 1) % 16;
      end else if (w[12:11] == 2'b01) begin
        cyc += 2;
        pc = (acc == 8'h00) ? int'(w[3:0]) : (pc + 1) % 16;
      end else begin
        cyc += 2;
        pc = (pc + 1) % 16;
      end
      steps++;
      if (steps == 255) begin
        err = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) prog[i] = enc(2, 0, 0);
  endtask

  // Returns the number of clock edges from the accepting edge to the done edge.
  task automatic run(input logic [7:0] a0, output int cyc);
    @(negedge clk);
    acc_init = a0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b exp 0", error); end
    if (accum !== 8'h00) begin errors++; $display("FAIL reset_accum got %h exp 00", accum); end
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    if (opcode !== 3'b000) begin errors++; $display("FAIL reset_opcode got %0d exp 0", opcode); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_program();
    int cyc, msteps, mcyc;
    logic [7:0] macc;
    logic merr;
    fill_halt();
    prog[0] = enc(0, 1, 8'h05);
    prog[1] = enc(0, 1, 8'h03);
    load_prog();
    model_run(8'h00, macc, merr, msteps, mcyc);
    run(8'h00, cyc);
    checks += 4;
    if (cyc !== 8) begin errors++; $display("FAIL add_latency got %0d exp 8", cyc); end
    if (accum !== 8'h08) begin errors++; $display("FAIL add_accum got %h exp 08", accum); end
    if (error !== 1'b0) begin errors++; $display("FAIL add_error got %0b exp 0", error); end
    if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done got %0b exp 0", busy); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (retired !== 8'd2) begin errors++; $display("FAIL add_retired got %0d exp 2", retired); end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %0b exp 0", done); end
  endtask

  task automatic test_bz_taken();
    int cyc, msteps, mcyc;
    logic [7:0] macc;
    logic merr;
    fill_halt();
    prog[0] = enc(0, 2, 8'h08);
    prog[1] = enc(1, 0, 3);
    prog[2] = enc(0, 1, 8'h01);
    load_prog();
    model_run(8'h08, macc, merr, msteps, mcyc);
    run(8'h08, cyc);
    checks += 2;
    if (accum !== 8'h00) begin errors++; $display("FAIL bz_accum got %h exp 00", accum); end
    if (cyc !== 7) begin errors++; $display("FAIL bz_latency got %0d exp 7", cyc); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (retired !== 8'd2) begin errors++; $display("FAIL bz_retired got %0d exp 2", retired); end
`endif
  endtask

  task automatic test_mul_signed();
    int cyc;
    fill_halt();
    prog[0] = enc(0, 6, 8'h02);
    load_prog();
    run(8'h0D, cyc);
    checks += 2;
    if (accum !== 8'hFA) begin errors++; $display("FAIL mul_accum got %h exp fa", accum); end
    if (cyc !== 5) begin errors++; $display("FAIL mul_latency got %0d exp 5", cyc); end
  endtask

  task automatic test_nop_wrap_abort();
    int cyc;
    for (int i = 0; i < 16; i++) prog[i] = enc(3, 0, 0);
    load_prog();
    run(8'h5A, cyc);
    checks += 3;
    if (error !== 1'b1) begin errors++; $display("FAIL abort_error got %0b exp 1", error); end
    if (cyc !== 510) begin errors++; $display("FAIL abort_latency got %0d exp 510", cyc); end
    if (accum !== 8'h5A) begin errors++; $display("FAIL abort_accum got %h exp 5a", accum); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (retired !== 8'd255) begin errors++; $display("FAIL abort_retired got %0d exp 255", retired); end
`endif
  endtask

  task automatic test_reset_midrun();
    int cyc, msteps, mcyc;
    logic [7:0] macc;
    logic merr;
    logic saw_done;
    fill_halt();
    prog[0] = enc(0, 1, 8'h11);
    prog[1] = enc(0, 1, 8'h22);
    prog[2] = enc(0, 1, 8'h33);
    load_prog();
    model_run(8'h01, macc, merr, msteps, mcyc);
    @(negedge clk);
    acc_init = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
    if (accum !== 8'h00) begin errors++; $display("FAIL midrst_accum got %h exp 00", accum); end
    if (opcode !== 3'b000) begin errors++; $display("FAIL midrst_opcode got %0d exp 0", opcode); end
    saw_done = done;
    repeat (4) begin
      @(negedge clk);
      saw_done |= done;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %0b exp 0", saw_done); end
    run(8'h01, cyc);
    checks += 2;
    if (accum !== macc) begin errors++; $display("FAIL midrst_rerun_accum got %h exp %h", accum, macc); end
    if (cyc !== mcyc) begin errors++; $display("FAIL midrst_rerun_latency got %0d exp %0d", cyc, mcyc); end
  endtask

  task automatic test_ignore_busy();
    int cyc, msteps, mcyc;
    logic [7:0] macc;
    logic merr;
    fill_halt();
    prog[0] = enc(0, 1, 8'h05);
    prog[1] = enc(0, 1, 8'h03);
    load_prog();
    model_run(8'h10, macc, merr, msteps, mcyc);
    @(negedge clk);
    acc_init = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (cyc == 2 || cyc == 4) begin
        start = 1'b1; acc_init = 8'hEE;
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = enc(0, 7, 8'h7F);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; prog_we = 1'b0;
    checks += 2;
    if (accum !== macc) begin errors++; $display("FAIL busy_ignore_accum got %h exp %h", accum, macc); end
    if (cyc !== mcyc) begin errors++; $display("FAIL busy_ignore_latency got %0d exp %0d", cyc, mcyc); end
    run(8'h10, cyc);
    checks++;
    if (accum !== macc) begin errors++; $display("FAIL busy_ignore_mem got %h exp %h", accum, macc); end
  endtask

  task automatic test_random();
    int cyc, msteps, mcyc, k;
    logic [7:0] macc, a0;
    logic merr;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) begin
        k = $urandom_range(0, 9);
        if (k < 6)      prog[i] = enc(0, $urandom_range(0, 7), $urandom_range(0, 255));
        else if (k < 8) prog[i] = enc(1, 0, $urandom_range(0, 15));
        else if (k < 9) prog[i] = enc(3, 0, 0);
        else            prog[i] = enc(2, 0, 0);
      end
      a0 = 8'($urandom_range(0, 255));
      load_prog();
      model_run(a0, macc, merr, msteps, mcyc);
      run(a0, cyc);
      checks += 3;
      if (accum !== macc) begin errors++; $display("FAIL rand%0d_accum got %h exp %h", r, accum, macc); end
      if (error !== merr) begin errors++; $display("FAIL rand%0d_error got %0b exp %0b", r, error, merr); end
      if (cyc !== mcyc) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", r, cyc, mcyc); end
`ifdef INSTR_COUNT_EN
      checks++;
      if (retired !== 8'(msteps)) begin errors++; $display("FAIL rand%0d_retired got %0d exp %0d", r, retired, msteps); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; acc_init = '0;
    test_reset();
    test_add_program();
    test_bz_taken();
    test_mul_signed();
    test_nop_wrap_abort();
    test_reset_midrun();
    test_ignore_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
